// File: rtl/cbus_axi_bridge_pkg.sv
// Shared types for the CBus-to-AXI3 bridge: CBus request/response records,
// AXI encodings and the bridge FSM state type.
package cbus_axi_bridge_pkg;

   localparam int CBUS_ADDR_W = 32;
   localparam int CBUS_DATA_W = 32;
   localparam int CBUS_LEN_W  = 8;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   typedef struct packed {
      logic                   valid;
      logic                   is_write;
      logic [2:0]             size;
      logic [CBUS_ADDR_W-1:0] addr;
      logic [3:0]             strobe;
      logic [CBUS_DATA_W-1:0] data;
      logic [CBUS_LEN_W-1:0]  len;
   } cbus_req_t;

   typedef struct packed {
      logic                   ready;
      logic                   last;
      logic [CBUS_DATA_W-1:0] data;
   } cbus_resp_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_AR,
      ST_R,
      ST_AW,
      ST_W,
      ST_B
   } bridge_state_t;

endpackage

// File: rtl/cbus_axi_bridge_rr_arbiter.sv
// Round-robin arbiter: picks the lowest requesting index at or after ptr,
// wrapping past NUM_PORTS-1 back to 0.
module cbus_axi_bridge_rr_arbiter #(
   parameter int NUM_PORTS = 3,
   parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [IDX_W-1:0]     ptr,
   output logic [NUM_PORTS-1:0] grant,
   output logic [IDX_W-1:0]     grant_idx
);

   function automatic logic [IDX_W-1:0] wrap_idx(input int i);
      return (i >= NUM_PORTS) ? IDX_W'(i - NUM_PORTS) : IDX_W'(i);
   endfunction

   // Scan from the farthest offset down so the closest requester wins.
   always_comb begin
      grant_idx = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         if (req[wrap_idx(int'(ptr) + k)]) grant_idx = wrap_idx(int'(ptr) + k);
      end
      grant = (|req) ? (NUM_PORTS'(1) << grant_idx) : '0;
   end

endmodule

// File: rtl/cbus_axi_bridge.sv
// NUM_PORTS CBus masters sharing one AXI3 master port, one transaction at a time,
// with round-robin grant, INCR bursts and error/protocol monitoring.
module cbus_axi_bridge
   import cbus_axi_bridge_pkg::*;
#(
   parameter int NUM_PORTS = 3,
   parameter int ID_W      = 4,
   parameter int MAX_LEN   = 16,
   parameter int ERR_CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  cbus_req_t              creq [NUM_PORTS],
   output cbus_resp_t             cresp [NUM_PORTS],
   output logic [ID_W-1:0]        arid,
   output logic [CBUS_ADDR_W-1:0] araddr,
   output logic [3:0]             arlen,
   output logic [2:0]             arsize,
   output logic [1:0]             arburst,
   output logic [1:0]             arlock,
   output logic [3:0]             arcache,
   output logic [2:0]             arprot,
   output logic                   arvalid,
   input  logic                   arready,
   input  logic [CBUS_DATA_W-1:0] rdata,
   input  logic [1:0]             rresp,
   input  logic                   rlast,
   input  logic                   rvalid,
   output logic                   rready,
   output logic [ID_W-1:0]        awid,
   output logic [CBUS_ADDR_W-1:0] awaddr,
   output logic [3:0]             awlen,
   output logic [2:0]             awsize,
   output logic [1:0]             awburst,
   output logic [1:0]             awlock,
   output logic [3:0]             awcache,
   output logic [2:0]             awprot,
   output logic                   awvalid,
   input  logic                   awready,
   output logic [ID_W-1:0]        wid,
   output logic [CBUS_DATA_W-1:0] wdata,
   output logic [3:0]             wstrb,
   output logic                   wlast,
   output logic                   wvalid,
   input  logic                   wready,
   input  logic [1:0]             bresp,
   input  logic                   bvalid,
   output logic                   bready,
   output logic [ERR_CNT_W-1:0]   err_count,
   output logic                   proto_err
);

   localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   bridge_state_t          state, state_next;
   logic [NUM_PORTS-1:0]   req, grant_oh;
   logic [IDX_W-1:0]       grant_idx, grant_q, ptr_q;
   logic [CBUS_ADDR_W-1:0] addr_q;
   logic [2:0]             size_q;
   logic [3:0]             len_q;
   logic [CBUS_LEN_W-1:0]  count_q;
   logic                   any_req, rd_beat, wr_beat, b_done;

   function automatic logic len_over(input logic [CBUS_LEN_W-1:0] l);
      return l > CBUS_LEN_W'(MAX_LEN - 1);
   endfunction

   function automatic logic [3:0] clamp_len(input logic [CBUS_LEN_W-1:0] l);
      return len_over(l) ? 4'(MAX_LEN - 1) : l[3:0];
   endfunction

   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
      return (&c) ? c : c + ERR_CNT_W'(1);
   endfunction

   function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] g);
      return (g == IDX_W'(NUM_PORTS - 1)) ? '0 : g + IDX_W'(1);
   endfunction

   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) req[i] = creq[i].valid;
   end

   cbus_axi_bridge_rr_arbiter #(
      .NUM_PORTS (NUM_PORTS),
      .IDX_W     (IDX_W)
   ) u_arb (
      .req       (req),
      .ptr       (ptr_q),
      .grant     (grant_oh),
      .grant_idx (grant_idx)
   );

   assign any_req = |grant_oh;
   assign rd_beat = (state == ST_R) && rvalid;
   assign wr_beat = (state == ST_W) && wready;
   assign b_done  = (state == ST_B) && bvalid;

   // Only one transaction is ever outstanding, so response ids carry no information.
   assign arid    = ID_W'(grant_q);
   assign araddr  = addr_q;
   assign arlen   = len_q;
   assign arsize  = size_q;
   assign arburst = AXI_BURST_INCR;
   assign arlock  = '0;
   assign arcache = '0;
   assign arprot  = '0;
   assign awid    = ID_W'(grant_q);
   assign awaddr  = addr_q;
   assign awlen   = len_q;
   assign awsize  = size_q;
   assign awburst = AXI_BURST_INCR;
   assign awlock  = '0;
   assign awcache = '0;
   assign awprot  = '0;
   assign wid     = ID_W'(grant_q);
   assign wdata   = creq[grant_q].data;
   assign wstrb   = creq[grant_q].strobe;

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      arvalid    = 1'b0;
      awvalid    = 1'b0;
      wvalid     = 1'b0;
      rready     = 1'b0;
      bready     = 1'b0;
      wlast      = (count_q == CBUS_LEN_W'(len_q));
      for (int i = 0; i < NUM_PORTS; i++) cresp[i] = '{ready: 1'b0, last: 1'b0, data: rdata};
      case (state)
         ST_IDLE: if (any_req) state_next = creq[grant_idx].is_write ? ST_AW : ST_AR;
         ST_AR: begin
            arvalid = 1'b1;
            if (arready) state_next = ST_R;
         end
         ST_R: begin
            rready = 1'b1;
            if (rvalid) begin
               cresp[grant_q].ready = 1'b1;
               cresp[grant_q].last  = rlast;
               if (rlast) state_next = ST_IDLE;
            end
         end
         ST_AW: begin
            awvalid = 1'b1;
            if (awready) state_next = ST_W;
         end
         ST_W: begin
            wvalid = 1'b1;
            if (wready) begin
               cresp[grant_q].ready = 1'b1;
               cresp[grant_q].last  = wlast;
               if (wlast) state_next = ST_B;
            end
         end
         ST_B: begin
            bready = 1'b1;
            if (bvalid) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Request fields are captured once at grant; the master may drop valid afterwards.
   always_ff @(posedge clk) begin
      if (state == ST_IDLE && any_req) begin
         grant_q <= grant_idx;
         addr_q  <= creq[grant_idx].addr;
         size_q  <= creq[grant_idx].size;
         len_q   <= clamp_len(creq[grant_idx].len);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q     <= '0;
         count_q   <= '0;
         err_count <= '0;
         proto_err <= 1'b0;
      end else begin
         if (state == ST_IDLE) count_q <= '0;
         if (state == ST_IDLE && any_req && len_over(creq[grant_idx].len)) proto_err <= 1'b1;
         if (rd_beat) begin
            count_q <= count_q + CBUS_LEN_W'(1);
            if (rlast != (count_q == CBUS_LEN_W'(len_q))) proto_err <= 1'b1;
            if (rresp != AXI_RESP_OKAY) err_count <= sat_inc(err_count);
         end
         if (wr_beat) count_q <= count_q + CBUS_LEN_W'(1);
         if (b_done && bresp != AXI_RESP_OKAY) err_count <= sat_inc(err_count);
         if ((rd_beat && rlast) || b_done) ptr_q <= next_ptr(grant_q);
      end
   end

endmodule

// File: tb/tb_cbus_axi_bridge.sv
// Directed and randomized bench for cbus_axi_bridge with a transaction-level
// model of arbitration order, error counting and protocol flags.
module tb_cbus_axi_bridge;
   import cbus_axi_bridge_pkg::*;

   localparam int NP   = 3;
   localparam int ID_W = 4;

   logic        clk = 1'b0;
   logic        reset;
   cbus_req_t   creq [NP];
   cbus_resp_t  cresp [NP];
   logic [ID_W-1:0] arid, awid, wid;
   logic [31:0] araddr, awaddr, rdata, wdata;
   logic [3:0]  arlen, awlen, arcache, awcache, wstrb;
   logic [2:0]  arsize, awsize, arprot, awprot;
   logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic [7:0]  err_count;
   logic        proto_err;

   always #5 clk = ~clk;

   cbus_axi_bridge #(.NUM_PORTS(NP), .ID_W(ID_W), .MAX_LEN(16), .ERR_CNT_W(8)) dut (
      .clk(clk), .reset(reset), .creq(creq), .cresp(cresp),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .err_count(err_count), .proto_err(proto_err)
   );

   int checks = 0;
   int failures = 0;

   // Reference state: round-robin pointer, error counter, sticky protocol flag.
   int m_ptr = 0;
   int m_err = 0;
   bit m_proto = 1'b0;
   logic [31:0] rd_fixed = '0;

   bit          wr_a [NP];
   logic [31:0] addr_a [NP];
   int          len_a [NP];
   logic [31:0] dbase_a [NP];
   logic [3:0]  strb_a [NP];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int model_grant(input bit [NP-1:0] pend);
      for (int k = 0; k < NP; k++) begin
         if (pend[(m_ptr + k) % NP]) return (m_ptr + k) % NP;
      end
      return 0;
   endfunction

   function automatic int sat(input int c);
      return (c >= 255) ? 255 : c + 1;
   endfunction

   task automatic post(input int p, input bit wr, input logic [31:0] a, input int l,
                       input logic [31:0] d, input logic [3:0] s);
      wr_a[p] = wr; addr_a[p] = a; len_a[p] = l; dbase_a[p] = d; strb_a[p] = s;
      creq[p].valid = 1'b1; creq[p].is_write = wr; creq[p].size = 3'd2;
      creq[p].addr = a; creq[p].len = 8'(l); creq[p].data = d; creq[p].strobe = s;
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_arvalid"}, arvalid, 0);
      chk({tag, "_awvalid"}, awvalid, 0);
      chk({tag, "_wvalid"}, wvalid, 0);
      chk({tag, "_rready"}, rready, 0);
      chk({tag, "_bready"}, bready, 0);
      for (int q = 0; q < NP; q++) begin
         chk({tag, "_cresp_ready"}, cresp[q].ready, 0);
         chk({tag, "_cresp_last"}, cresp[q].last, 0);
      end
      chk({tag, "_err_count"}, err_count, m_err);
      chk({tag, "_proto_err"}, proto_err, m_proto);
   endtask

   // Serve the transaction of port p: address phase, data beats, response.
   task automatic serve(input int p, input int early_last, input int err_mask);
      int elen;
      bit got;
      bit lastb;
      logic [31:0] rd;
      elen = (len_a[p] > 15) ? 15 : len_a[p];
      if (len_a[p] > 15) m_proto = 1'b1;
      got = 1'b0;
      for (int lim = 0; lim < 20 && !got; lim++) begin
         @(negedge clk);
         got = wr_a[p] ? awvalid : arvalid;
      end
      chk("addr_valid_seen", got, 1);
      if (!got) return;
      chk("ar_aw_exclusive", arvalid & awvalid, 0);
      if (wr_a[p]) begin
         chk("awid", awid, p); chk("awaddr", awaddr, addr_a[p]);
         chk("awlen", awlen, elen); chk("awburst", awburst, 2'b01);
         awready = 1'b1;
      end else begin
         chk("arid", arid, p); chk("araddr", araddr, addr_a[p]);
         chk("arlen", arlen, elen); chk("arburst", arburst, 2'b01);
         chk("arsize", arsize, 2);
         arready = 1'b1;
      end
      @(posedge clk); #1;
      arready = 1'b0; awready = 1'b0; creq[p].valid = 1'b0;
      if (!wr_a[p]) begin
         for (int b = 0; b <= 16; b++) begin
            rd = (rd_fixed != 0) ? rd_fixed + 32'(b) : $urandom;
            lastb = (early_last >= 0) ? (b == early_last) : (b == elen);
            rvalid = 1'b1; rdata = rd; rlast = lastb;
            rresp = ((err_mask >> b) & 1) != 0 ? 2'b10 : 2'b00;
            @(negedge clk);
            chk("rready", rready, 1);
            chk("rd_cresp_ready", cresp[p].ready, 1);
            chk("rd_cresp_data", cresp[p].data, rd);
            chk("rd_cresp_last", cresp[p].last, lastb);
            for (int q = 0; q < NP; q++) if (q != p) chk("rd_other_ready", cresp[q].ready, 0);
            if (rresp != 2'b00) m_err = sat(m_err);
            if (lastb != (b == elen)) m_proto = 1'b1;
            @(posedge clk); #1;
            if (lastb) break;
         end
         rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      end else begin
         for (int b = 0; b <= elen; b++) begin
            creq[p].data = dbase_a[p] + 32'(b); creq[p].strobe = strb_a[p];
            if ($urandom_range(0, 1) == 1) begin
               wready = 1'b0;
               @(negedge clk);
               chk("w_stall_wvalid", wvalid, 1);
               chk("w_stall_cresp_ready", cresp[p].ready, 0);
               @(posedge clk); #1;
            end
            wready = 1'b1;
            @(negedge clk);
            chk("wvalid", wvalid, 1);
            chk("wdata", wdata, dbase_a[p] + 32'(b));
            chk("wstrb", wstrb, strb_a[p]);
            chk("wlast", wlast, b == elen);
            chk("wid", wid, p);
            chk("wr_cresp_ready", cresp[p].ready, 1);
            chk("wr_cresp_last", cresp[p].last, b == elen);
            for (int q = 0; q < NP; q++) if (q != p) chk("wr_other_ready", cresp[q].ready, 0);
            @(posedge clk); #1;
         end
         wready = 1'b0;
         @(negedge clk);
         chk("bready_wait", bready, 1);
         chk("b_cresp_ready", cresp[p].ready, 0);
         @(posedge clk); #1;
         bvalid = 1'b1;
         bresp = ((err_mask & 1) != 0) ? 2'b11 : 2'b00;
         @(negedge clk);
         chk("bready", bready, 1);
         if (bresp != 2'b00) m_err = sat(m_err);
         @(posedge clk); #1;
         bvalid = 1'b0; bresp = 2'b00;
      end
      m_ptr = (p + 1) % NP;
      @(negedge clk);
      check_idle("post_txn");
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit [NP-1:0] pend;
      bit got;
      int p;
      reset = 1'b1;
      arready = 0; rvalid = 0; rlast = 0; rresp = 0; rdata = 0;
      awready = 0; wready = 0; bvalid = 0; bresp = 0;
      for (int q = 0; q < NP; q++) creq[q] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle("reset");
      @(posedge clk); #1;
      reset = 1'b0;

      // Port 0 four-beat read with known data.
      rd_fixed = 32'hA;
      post(0, 1'b0, 32'h1fc0_0000, 3, 0, 0);
      serve(0, -1, 0);
      rd_fixed = '0;

      // Port 1 single-beat write with half-word strobe.
      post(1, 1'b1, 32'h8000_0010, 0, 32'h1234, 4'b0011);
      serve(1, -1, 0);

      // Three simultaneous requesters, then round-robin precedence check.
      post(0, 1'b0, 32'h100, 0, 0, 0);
      post(1, 1'b0, 32'h200, 0, 0, 0);
      post(2, 1'b0, 32'h300, 0, 0, 0);
      pend = 3'b111;
      while (pend != 0) begin
         p = model_grant(pend);
         serve(p, -1, 0);
         pend[p] = 1'b0;
      end
      post(0, 1'b0, 32'h400, 0, 0, 0);
      post(1, 1'b0, 32'h500, 0, 0, 0);
      pend = 3'b011;
      while (pend != 0) begin
         p = model_grant(pend);
         serve(p, -1, 0);
         pend[p] = 1'b0;
      end
      post(0, 1'b0, 32'h600, 0, 0, 0);
      post(2, 1'b0, 32'h700, 0, 0, 0);
      pend = 3'b101;
      while (pend != 0) begin
         p = model_grant(pend);
         serve(p, -1, 0);
         pend[p] = 1'b0;
      end

      // Error responses: two read beats plus one write response.
      post(2, 1'b0, 32'h800, 1, 0, 0);
      serve(2, -1, 3);
      post(0, 1'b1, 32'h900, 0, 32'h55, 4'hF);
      serve(0, -1, 1);
      chk("err_count_three", err_count, 3);

      // Early rlast on the second beat of a four-beat burst.
      post(1, 1'b0, 32'hA00, 3, 0, 0);
      serve(1, 1, 0);
      post(2, 1'b0, 32'hB00, 0, 0, 0);
      serve(2, -1, 0);
      chk("proto_sticky", proto_err, 1);

      // Drive the error counter into saturation.
      for (int i = 0; i < 17; i++) begin
         p = m_ptr;
         post(p, 1'b0, 32'hC00, 15, 0, 0);
         serve(p, -1, 32'h0001_FFFF);
      end
      chk("err_count_saturated", err_count, 8'hFF);

      // Randomized mixes of requesters, directions, lengths and errors.
      for (int it = 0; it < 25; it++) begin
         pend = 3'($urandom_range(1, 7));
         for (int q = 0; q < NP; q++) begin
            if (pend[q]) post(q, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
                              $urandom_range(0, 17), $urandom, 4'($urandom_range(0, 15)));
         end
         while (pend != 0) begin
            p = model_grant(pend);
            serve(p, -1, ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 65535)) : 0);
            pend[p] = 1'b0;
         end
      end

      // Reset while the second write beat is offered.
      post(0, 1'b1, 32'hD00, 3, 32'h7700, 4'hF);
      got = 1'b0;
      for (int lim = 0; lim < 20 && !got; lim++) begin
         @(negedge clk);
         got = awvalid;
      end
      chk("abort_aw_seen", got, 1);
      awready = 1'b1;
      @(posedge clk); #1;
      awready = 1'b0; creq[0].valid = 1'b0;
      wready = 1'b1;
      @(posedge clk); #1;
      wready = 1'b0;
      @(negedge clk);
      chk("abort_w_beat2_valid", wvalid, 1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      m_ptr = 0; m_err = 0; m_proto = 1'b0;
      @(negedge clk);
      check_idle("after_abort");
      post(1, 1'b0, 32'hE00, 2, 0, 0);
      serve(1, -1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
